dsp_sample_fifo: RTL
====================

// Module: dsp_sample_fifo
// PURPOSE
//  Single-clock, multi-channel audio sample FIFO in the DSP domain; successor to the CDC packet FIFO.
//  Absorbs bursty per-frame writes (e.g. CDC output, one packet per frame) and releases one
//  frame per sample-rate strobe. Adds configurable depth/channels, prefill priming, and
//  selectable underrun/overrun policies with sticky error flags.
// PARAMETERS
//  PKT_WIDTH      16  bits per channel sample
//  NUM_CH         2   channels per frame; frame = NUM_CH*PKT_WIDTH bits, ch0 in LSBs
//  DEPTH          8   frames stored; power of 2, >=2
//  PRIME_LEVEL    4   frames required before reads are served; 1..DEPTH
//  UNDERRUN_MODE  0   0 = repeat last output frame, 1 = output all-zero frame
//  OVERRUN_MODE   0   0 = drop incoming frame, 1 = overwrite oldest frame
// PORTS
//  clkDSP_i           in   1                  DSP clock, sole clock
//  rstDSP_i           in   1                  async reset, active-high
//  pkt_i              in   NUM_CH*PKT_WIDTH   write frame
//  pktChanged_i       in   1                  write strobe, 1 cycle per frame
//  rdEN_i             in   1                  read strobe (sample-rate tick)
//  flush_i            in   1                  sync clear of contents
//  clrErr_i           in   1                  clears sticky error flags
//  pktOut_s_o         out  NUM_CH*PKT_WIDTH   registered output frame
//  pktOutChanged_s_o  out  1                  1-cycle pulse, pktOut_s_o updated
//  level_s_o          out  $clog2(DEPTH+1)    frames stored, 0..DEPTH
//  full_s_o           out  1                  level == DEPTH
//  empty_s_o          out  1                  level == 0
//  priming_s_o        out  1                  state == PRIMING
//  overrun_s_o        out  1                  sticky: overrun occurred
//  underrun_s_o       out  1                  sticky: underrun occurred
// BEHAVIOUR
//  - Reset (async, any time): ptrs=0, level=0, state=PRIMING, all outputs 0 except
//    empty_s_o=1, priming_s_o=1. Contents of storage undefined.
//  - States: PRIMING -> RUNNING when registered level >= PRIME_LEVEL (takes effect next cycle).
//    RUNNING -> PRIMING on underrun or flush. PRIMING -> PRIMING on flush.
//  - Write: pktChanged_i=1 and not full -> store at wr ptr, wr ptr++ (wraps mod DEPTH), level++.
//  - Read in RUNNING with level>0: pktOut_s_o <= head frame on next edge (latency 1 cycle),
//    pktOutChanged_s_o=1 that cycle, rd ptr++, level--.
//  - Read in RUNNING with level==0: underrun; output fill frame per UNDERRUN_MODE, pulse still
//    asserted, underrun_s_o<=1, state->PRIMING. Same-cycle write is stored (no bypass); level=1.
//  - Read in PRIMING: fill frame per UNDERRUN_MODE, pulse asserted, no flag, no pointer change.
//  - Write when full, no read: OVERRUN_MODE 0 drops frame; mode 1 stores frame, advances rd ptr,
//    level stays DEPTH. Either mode sets overrun_s_o.
//  - Simultaneous read+write when full (RUNNING): read served, write accepted, no overrun, level=DEPTH.
//  - Simultaneous read+write, 0<level<DEPTH: level unchanged, both ptrs advance.
//  - flush_i: highest priority; ptrs=0, level=0, state=PRIMING; same-cycle read/write ignored;
//    pktOut_s_o and error flags hold.
//  - clrErr_i clears both sticky flags; a new error in the same cycle wins (flag stays 1).
//  - Flags full/empty/level/priming registered, consistent with each other every cycle.
// TESTING
//  - Reset, write 0x0001_0002 x4 (PRIME=4), rdEN 1 cycle later -> pktOut=0x00010002, pulse 1 cycle, level 4->3.
//  - Write 3 frames, rdEN x2 -> 2 pulses with fill frame (0 after reset), level stays 3, priming_s_o=1.
//  - Prime with A,B,C,D; 5 rdEN -> A,B,C,D then underrun: mode0 repeats D, mode1 0; underrun_s_o=1, priming=1.
//  - DEPTH=8: write 9 frames 1..9 no reads -> mode0 holds 1..8; mode1 holds 2..9; overrun_s_o=1; read order checked.
//  - Full FIFO, same-cycle write+rdEN -> no overrun, level 8, output = oldest frame.
//  - Mid-stream flush_i with write+rdEN same cycle -> level 0, priming 1, pktOut holds; async rstDSP_i mid-burst -> all outputs reset values immediately.

Source files
------------

// File: rtl/dsp_sample_fifo_if.sv
// dsp_sample_fifo_if: frame write/read strobes and status bundle for dsp_sample_fifo
interface dsp_sample_fifo_if #(
  parameter int PKT_WIDTH = 16,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 8
);
  localparam int FW = NUM_CH * PKT_WIDTH;
  localparam int LW = $clog2(DEPTH + 1);
  logic [FW-1:0] pkt_i;
  logic          pktChanged_i;
  logic          rdEN_i;
  logic          flush_i;
  logic          clrErr_i;
  logic [FW-1:0] pktOut_s_o;
  logic          pktOutChanged_s_o;
  logic [LW-1:0] level_s_o;
  logic          full_s_o;
  logic          empty_s_o;
  logic          priming_s_o;
  logic          overrun_s_o;
  logic          underrun_s_o;
  modport master (
    output pkt_i, pktChanged_i, rdEN_i, flush_i, clrErr_i,
    input  pktOut_s_o, pktOutChanged_s_o, level_s_o, full_s_o, empty_s_o,
           priming_s_o, overrun_s_o, underrun_s_o
  );
  modport slave (
    input  pkt_i, pktChanged_i, rdEN_i, flush_i, clrErr_i,
    output pktOut_s_o, pktOutChanged_s_o, level_s_o, full_s_o, empty_s_o,
           priming_s_o, overrun_s_o, underrun_s_o
  );
endinterface

// File: rtl/dsp_sample_fifo.sv
// dsp_sample_fifo: multi-channel frame FIFO releasing one frame per sample strobe after priming
module dsp_sample_fifo #(
  parameter int PKT_WIDTH     = 16,
  parameter int NUM_CH        = 2,
  parameter int DEPTH         = 8,
  parameter int PRIME_LEVEL   = 4,
  parameter int UNDERRUN_MODE = 0,
  parameter int OVERRUN_MODE  = 0
) (
  input logic               clkDSP_i,
  input logic               rstDSP_i,
  dsp_sample_fifo_if.slave  s
);
  localparam int FW = NUM_CH * PKT_WIDTH;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {PRIMING, RUNNING} state_t;
  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level, w_level_nxt;
  logic [FW-1:0] r_out;
  logic          r_pulse, r_full, r_empty, r_ovr, r_und;
  logic          w_run, w_req_rd, w_rd, w_und, w_fill, w_wr, w_ovr, w_inc, w_store, w_rd_adv;
  assign w_run      = (r_state == RUNNING);
  assign w_req_rd   = s.rdEN_i && !s.flush_i;
  assign w_rd       = w_req_rd && w_run && !r_empty;
  assign w_und      = w_req_rd && w_run && r_empty;
  assign w_fill     = w_req_rd && !w_rd;
  assign w_wr       = s.pktChanged_i && !s.flush_i;
  // a read served this cycle frees the slot, so a full FIFO still accepts the write
  assign w_ovr      = w_wr && r_full && !w_rd;
  assign w_inc      = w_wr && !w_ovr;
  assign w_store    = w_inc || (w_ovr && (OVERRUN_MODE == 1));
  assign w_rd_adv   = w_rd || (w_ovr && (OVERRUN_MODE == 1));
  assign w_level_nxt = s.flush_i ? '0 : r_level + LW'(w_inc) - LW'(w_rd);
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (s.flush_i || w_und) ? PRIMING :
                  (!w_run && r_level >= LW'(PRIME_LEVEL)) ? RUNNING : r_state;
  end
  always_ff @(posedge clkDSP_i or posedge rstDSP_i) begin
    if (rstDSP_i) begin
      r_state <= PRIMING;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_out   <= '0;
      r_pulse <= 1'b0;
      r_ovr   <= 1'b0;
      r_und   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= s.flush_i ? '0 : r_wr + AW'(w_store);
      r_rd    <= s.flush_i ? '0 : r_rd + AW'(w_rd_adv);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
      r_pulse <= w_rd || w_fill;
      r_out   <= w_rd ? r_mem[r_rd] : (w_fill && (UNDERRUN_MODE == 1)) ? '0 : r_out;
      r_ovr   <= w_ovr || (r_ovr && !s.clrErr_i);
      r_und   <= w_und || (r_und && !s.clrErr_i);
    end
  end
  always_ff @(posedge clkDSP_i) begin
    if (w_store) r_mem[r_wr] <= s.pkt_i;
  end
  assign s.pktOut_s_o        = r_out;
  assign s.pktOutChanged_s_o = r_pulse;
  assign s.level_s_o         = r_level;
  assign s.full_s_o          = r_full;
  assign s.empty_s_o         = r_empty;
  assign s.priming_s_o       = (r_state == PRIMING);
  assign s.overrun_s_o       = r_ovr;
  assign s.underrun_s_o      = r_und;
endmodule
